mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM controller and arbiter that shares the byte-wide main memory between the instruction fetch path (ins_cache miss fills) and the load/store buffer. It serialises 1/2/4-byte accesses into per-byte RAM cycles, assembles read data little-endian, holds I/O writes while the I/O buffer is full, and aborts speculative reads on flush. It sits between ins_cache / LSB and the top-level RAM pins.

## Interface
- IO_BASE, 'h30000, byte addresses >= IO_BASE are memory-mapped I/O
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  global run enable; 0 freezes all state
- flush  in  1  misprediction flush; aborts in-flight reads
- io_buffer_full  in  1  I/O output buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  `RAM_ADR_W  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- ic_req  in  1  ins_cache read request, level, held until ic_ok
- ic_addr  in  `RAM_ADR_W  word address for fetch, stable while ic_req
- ic_ok  out  1  one-cycle pulse, ic_data valid
- ic_data  out  `DAT_W  fetched 32-bit word
- ls_req  in  1  LSB request, level, held until ls_ok
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- ls_addr  in  `RAM_ADR_W  byte address
- ls_wdata  in  `DAT_W  store data, low bytes used
- ls_ok  out  1  one-cycle pulse, load data valid / store complete
- ls_rdata  out  `DAT_W  load data, zero-extended (sign extension is LSB's job)

## Operation
- States: IDLE, READ, WRITE, IO_WAIT, DONE.
- IDLE: if exactly one requester, grant it; if both, grant the one not granted last (round-robin, last_grant reset to ic so LSB wins first tie). ic is always a 4-byte read.
- Grant latches addr, size N (1/2/4), wdata, owner. Read -> READ; write with addr >= IO_BASE and io_buffer_full=1 -> IO_WAIT; other write -> WRITE.
- IO_WAIT: mem_wr=0; moves to WRITE at the first edge with io_buffer_full=0.
- WRITE: byte k (k=0..N-1) driven as mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1; after byte N-1 -> DONE.
- READ: mem_a=addr+k, mem_wr=0 for k=0..N-1; byte k sampled from mem_din one cycle after its address cycle into data[8k+7:8k]; after last byte captured -> DONE.
- DONE: owner's ok=1 for exactly one cycle with data; -> IDLE. Requests are not sampled in DONE; requester drops req at the edge ending the ok cycle.
- flush=1 during READ (either owner) or IO_WAIT-free read path: abort, -> IDLE next edge, no ok. flush in WRITE/IO_WAIT: ignored, store completes. flush in DONE: pulse still issued; requester discards.
- en=0: all registers hold, mem_wr forced 0. A READ/WRITE interrupted by en=0 restarts from byte 0 when en returns (rewrites identical bytes).
- Outside READ/WRITE: mem_a=0, mem_wr=0, mem_dout=0.

## Timing
- Reset: state=IDLE, last_grant=ic, mem_a=0, mem_dout=0, mem_wr=0, ic_ok=0, ls_ok=0, ic_data=0, ls_rdata=0.
- Grant edge E0; byte k address visible in cycle after E(k).
- Read of N bytes: ok high in the cycle after edge E(N+1) (word: 5 cycles after grant, 6-cycle occupancy incl. DONE).
- Write of N bytes: ok high in the cycle after E(N); IO_WAIT adds cycles 1:1 with io_buffer_full.
- Earliest next grant: edge ending the DONE cycle. Back-to-back ic word reads: one every 6 cycles.

## Structure
- utils/head.v: `RAM_ADR_W, `DAT_W, size codes (`SZ_B/`SZ_H/`SZ_W), state encodings.
- One sub-module natural: mem_rr_arb (2-way round-robin grant with last_grant register); byte sequencing stays in mem_arbiter.

## Test plan
- ic_req, ic_addr=0x100, RAM 0x100..0x103 = 13 05 00 00 -> ic_ok pulse 5 cycles after grant, ic_data=0x00000513, one pulse only.
- ls store word 0xDEADBEEF @0x200 -> mem_wr=1 four cycles, bytes EF BE AD DE at 0x200..0x203, ls_ok 4 cycles after grant; half load @0x202 -> ls_rdata=0x0000DEAD.
- ic_req and ls_req raised same cycle, held -> ls granted first, ic second; repeat with both held -> alternation ls, ic, ls.
- ls byte store 0x41 @IO_BASE with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then single write of 0x41, ls_ok.
- flush in 2nd cycle of ic READ -> no ic_ok, state IDLE next cycle, pending ls_req granted at following edge; flush during ls word store -> all 4 bytes written, ls_ok issued.
- rst asserted mid-READ -> all outputs reset values next cycle; en=0 for 2 cycles mid-write -> mem_wr=0 during pause, transaction restarts at byte 0, memory contents correct.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, size codes, state encodings and helpers for the RAM arbiter.
package mem_arbiter_pkg;

  localparam int unsigned RamAdrW = 32;
  localparam int unsigned DatW    = 32;

  // Byte addresses at or above this are memory-mapped I/O.
  localparam logic [RamAdrW-1:0] IoBase = 32'h0003_0000;

  // Access size codes (3 is illegal and behaves as a word).
  localparam logic [1:0] SzB = 2'd0;
  localparam logic [1:0] SzH = 2'd1;
  localparam logic [1:0] SzW = 2'd2;

  // Controller state encodings.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRead   = 3'd1;
  localparam logic [2:0] StWrite  = 3'd2;
  localparam logic [2:0] StIoWait = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  typedef enum logic {
    OwnIc = 1'b0,
    OwnLs = 1'b1
  } owner_e;

  // Number of RAM byte cycles for a size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SzB:     return 3'd1;
      SzH:     return 3'd2;
      SzW:     return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side bus of the memory arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // RAM pins
  logic [7:0]         mem_din;
  logic [7:0]         mem_dout;
  logic [RamAdrW-1:0] mem_a;
  logic               mem_wr;

  // Instruction fetch path
  logic               ic_req;
  logic [RamAdrW-1:0] ic_addr;
  logic               ic_ok;
  logic [DatW-1:0]    ic_data;

  // Load/store buffer path
  logic               ls_req;
  logic               ls_wr;
  logic [1:0]         ls_size;
  logic [RamAdrW-1:0] ls_addr;
  logic [DatW-1:0]    ls_wdata;
  logic               ls_ok;
  logic [DatW-1:0]    ls_rdata;

  // Arbiter side
  modport slave (
    input  mem_din, ic_req, ic_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr, ic_ok, ic_data, ls_ok, ls_rdata
  );

  // Requester / RAM side
  modport master (
    output mem_din, ic_req, ic_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr, ic_ok, ic_data, ls_ok, ls_rdata
  );

endinterface

// File: rtl/mem_rr_arb.sv
// Two-way round-robin grant between instruction fetch and load/store.
module mem_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,    // a grant taken this cycle updates the history
  input  logic req_ic,
  input  logic req_ls,
  output logic gnt_valid,
  output logic gnt_ls      // 1 = grant LSB, 0 = grant ic
);

  logic last_ls_q;

  // On a tie, favour whichever side was not granted last.
  always_comb begin
    gnt_valid = req_ic | req_ls;
    gnt_ls    = req_ls & (~req_ic | ~last_ls_q);
  end

  // Remember the most recent winner; reset to ic so LSB wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls_q <= 1'b0;
    end else if (arb_en && gnt_valid) begin
      last_ls_q <= gnt_ls;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM controller shared by ins_cache fills and the LSB.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          io_buffer_full,
  mem_arbiter_if.slave  bus
);

  logic [2:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         nbytes_q, nbytes_d;
  owner_e             owner_q, owner_d;
  logic [RamAdrW-1:0] addr_q, addr_d;
  logic [DatW-1:0]    wdata_q, wdata_d;
  logic [DatW-1:0]    data_q, data_d;

  logic req_ic_m, req_ls_m, arb_en, gnt_valid, gnt_ls;
  logic [1:0] rd_idx;

  // In DONE the owner's request is stale (it drops at the end of the ok cycle),
  // so only the other side may win the grant taken at that edge.
  assign req_ic_m = bus.ic_req & ~((state_q == StDone) & (owner_q == OwnIc));
  assign req_ls_m = bus.ls_req & ~((state_q == StDone) & (owner_q == OwnLs));
  assign arb_en   = en & ((state_q == StIdle) | (state_q == StDone));

  // Read data lags its address by one cycle, so cnt k captures byte k-1.
  assign rd_idx = 2'(cnt_q - 3'd1);

  mem_rr_arb u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .req_ic    (req_ic_m),
    .req_ls    (req_ls_m),
    .gnt_valid (gnt_valid),
    .gnt_ls    (gnt_ls)
  );

  // Next-state: grant, byte sequencing, read assembly, flush abort and pause.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;

    if (en) begin
      case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (gnt_valid) begin
            cnt_d  = '0;
            data_d = '0;
            if (gnt_ls) begin
              owner_d  = OwnLs;
              addr_d   = bus.ls_addr;
              nbytes_d = size_bytes(bus.ls_size);
              wdata_d  = bus.ls_wdata;
              if (!bus.ls_wr) begin
                state_d = StRead;
              end else if ((bus.ls_addr >= IoBase) && io_buffer_full) begin
                state_d = StIoWait;
              end else begin
                state_d = StWrite;
              end
            end else begin
              owner_d  = OwnIc;
              addr_d   = bus.ic_addr;
              nbytes_d = 3'd4;
              wdata_d  = '0;
              state_d  = StRead;
            end
          end
        end
        StRead: begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            if (cnt_q != 3'd0) begin
              data_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
            end
            if (cnt_q == nbytes_q) begin
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        StWrite: begin
          // Stores are committed; flush does not abort them.
          if (cnt_q == nbytes_q - 3'd1) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StIoWait: begin
          if (!io_buffer_full) begin
            state_d = StWrite;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if ((state_q == StRead) || (state_q == StWrite)) begin
      // A paused transfer restarts from byte 0 when enable returns.
      cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      nbytes_q <= '0;
      owner_q  <= OwnIc;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
    end
  end

  // RAM pins and completion handshakes.
  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    if ((state_q == StRead) && (cnt_q < nbytes_q)) begin
      bus.mem_a = addr_q + RamAdrW'(cnt_q);
    end else if (state_q == StWrite) begin
      bus.mem_a    = addr_q + RamAdrW'(cnt_q);
      bus.mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      bus.mem_wr   = en;
    end

    bus.ic_ok    = en & (state_q == StDone) & (owner_q == OwnIc);
    bus.ls_ok    = en & (state_q == StDone) & (owner_q == OwnLs);
    bus.ic_data  = (owner_q == OwnIc) ? data_q : '0;
    bus.ls_rdata = (owner_q == OwnLs) ? data_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst, en, flush, io_full;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .flush          (flush),
    .io_buffer_full (io_full),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, write on mem_wr.
  logic [7:0] ram [0:262143];
  int wr_count = 0;
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a[17:0]] <= bus.mem_dout;
      wr_count <= wr_count + 1;
    end
    bus.mem_din <= ram[bus.mem_a[17:0]];
  end

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit          is_ic;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input int unsigned a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_a"},    bus.mem_a, 32'h0);
    check({tag, " mem_wr"},   {31'b0, bus.mem_wr}, 32'h0);
    check({tag, " mem_dout"}, {24'b0, bus.mem_dout}, 32'h0);
    check({tag, " ic_ok"},    {31'b0, bus.ic_ok}, 32'h0);
    check({tag, " ls_ok"},    {31'b0, bus.ls_ok}, 32'h0);
    check({tag, " ic_data"},  bus.ic_data, 32'h0);
    check({tag, " ls_rdata"}, bus.ls_rdata, 32'h0);
  endtask

  // Issue one request, return cycles from grant edge to ok and the data seen.
  task automatic run_txn(input bit is_ic, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] data);
    lat  = -1;
    data = '0;
    if (is_ic) begin
      bus.ic_req  = 1'b1;
      bus.ic_addr = addr;
    end else begin
      bus.ls_req   = 1'b1;
      bus.ls_wr    = wr;
      bus.ls_size  = size;
      bus.ls_addr  = addr;
      bus.ls_wdata = wdata;
    end
    for (int n = 1; n <= 20; n++) begin
      step();
      if (is_ic ? bus.ic_ok : bus.ls_ok) begin
        lat  = n - 1;
        data = is_ic ? bus.ic_data : bus.ls_rdata;
        break;
      end
    end
    bus.ic_req = 1'b0;
    bus.ls_req = 1'b0;
    step();
    check("single ok pulse", {31'b0, bus.ic_ok | bus.ls_ok}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] data;
    int          ls_step, ic_step, k, w0, found, ic_seen;
    int          order [3];

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram['h100] = 8'h13;
    ram['h101] = 8'h05;

    rst = 1'b1; en = 1'b1; flush = 1'b0; io_full = 1'b0;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = SzB;
    bus.ls_addr = '0; bus.ls_wdata = '0;

    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    vecs[0] = '{1'b1, 1'b0, SzW,   32'h100, 32'h0,         32'h0000_0513, 5};
    vecs[1] = '{1'b0, 1'b1, SzW,   32'h200, 32'hDEAD_BEEF, 32'h0,         4};
    vecs[2] = '{1'b0, 1'b0, SzH,   32'h202, 32'h0,         32'h0000_DEAD, 3};
    vecs[3] = '{1'b0, 1'b0, SzB,   32'h201, 32'h0,         32'h0000_00BE, 2};
    vecs[4] = '{1'b0, 1'b0, SzW,   32'h200, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[5] = '{1'b0, 1'b1, SzB,   32'h300, 32'hFFFF_FF5A, 32'h0,         1};
    vecs[6] = '{1'b0, 1'b1, SzH,   32'h302, 32'h1234_ABCD, 32'h0,         2};
    vecs[7] = '{1'b0, 1'b0, SzW,   32'h300, 32'h0,         32'hABCD_005A, 5};
    vecs[8] = '{1'b0, 1'b0, 2'd3,  32'h200, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[9] = '{1'b1, 1'b0, SzW,   32'h200, 32'h0,         32'hDEAD_BEEF, 5};

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].is_ic, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, data);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].wr) check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
    end
    check("ram 0x200 word", ram_word(32'h200), 32'hDEAD_BEEF);
    check("ram 0x300 word", ram_word(32'h300), 32'hABCD_005A);
    check("ram 0x304 untouched", ram_word(32'h304), 32'h0);

    // Simultaneous requests: LSB wins the tie, ic granted at the DONE edge.
    ls_step = -1; ic_step = -1;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = SzW; bus.ls_addr = 32'h200;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (bus.ls_ok) begin
        ls_step = n;
        check("tie ls data", bus.ls_rdata, 32'hDEAD_BEEF);
        bus.ls_req = 1'b0;
      end
      if (bus.ic_ok) begin
        ic_step = n;
        check("tie ic data", bus.ic_data, 32'h0000_0513);
        bus.ic_req = 1'b0;
        break;
      end
    end
    check("tie ls ok cycle", 32'(ls_step), 32'd6);
    check("tie ic ok cycle", 32'(ic_step), 32'd12);
    step();

    // Both held continuously: grants alternate ls, ic, ls.
    k = 0;
    bus.ic_req = 1'b1; bus.ls_req = 1'b1;
    for (int n = 1; n <= 40 && k < 3; n++) begin
      step();
      if (bus.ls_ok) begin order[k] = 1; k++; end
      else if (bus.ic_ok) begin order[k] = 0; k++; end
    end
    check("alternation count", 32'(k), 32'd3);
    check("alternation 1st", 32'(order[0]), 32'd1);
    check("alternation 2nd", 32'(order[1]), 32'd0);
    check("alternation 3rd", 32'(order[2]), 32'd1);
    bus.ic_req = 1'b0; bus.ls_req = 1'b0;
    repeat (8) step();

    // I/O store held while the I/O buffer is full.
    io_full = 1'b1;
    w0 = wr_count;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = SzB;
    bus.ls_addr = IoBase; bus.ls_wdata = 32'h0000_0041;
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("io wait %0d mem_wr", n), {31'b0, bus.mem_wr}, 32'h0);
    end
    io_full = 1'b0;
    step();
    check("io write mem_wr", {31'b0, bus.mem_wr}, 32'h1);
    check("io write mem_a", bus.mem_a, IoBase);
    check("io write mem_dout", {24'b0, bus.mem_dout}, 32'h41);
    step();
    check("io ls_ok", {31'b0, bus.ls_ok}, 32'h1);
    bus.ls_req = 1'b0;
    step();
    check("io ram byte", {24'b0, ram[IoBase[17:0]]}, 32'h41);
    check("io write count", 32'(wr_count - w0), 32'd1);

    // Flush in the second cycle of an ic read; pending LSB load follows.
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    step();
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = SzB; bus.ls_addr = 32'h201;
    step();
    flush = 1'b1; bus.ic_req = 1'b0;
    step();
    flush = 1'b0;
    check("flush ic_ok", {31'b0, bus.ic_ok}, 32'h0);
    check("flush idle mem_a", bus.mem_a, 32'h0);
    step();
    check("post-flush ls grant mem_a", bus.mem_a, 32'h201);
    found = -1; ic_seen = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (bus.ic_ok) ic_seen++;
      if (bus.ls_ok) begin
        found = n;
        check("post-flush ls data", bus.ls_rdata, 32'h0000_00BE);
        break;
      end
    end
    check("post-flush ls ok cycle", 32'(found), 32'd2);
    check("flushed ic no ok", 32'(ic_seen), 32'd0);
    bus.ls_req = 1'b0;
    step();

    // Flush during a store is ignored.
    flush = 1'b1;
    run_txn(1'b0, 1'b1, SzW, 32'h400, 32'hCAFE_F00D, lat, data);
    flush = 1'b0;
    check("flush store latency", 32'(lat), 32'd4);
    check("flush store ram", ram_word(32'h400), 32'hCAFE_F00D);

    // Reset in the middle of a read.
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_reset_outputs("mid-read reset");
    rst = 1'b0; bus.ic_req = 1'b0;
    repeat (2) step();

    // Enable dropped for two cycles mid-store; transfer restarts at byte 0.
    w0 = wr_count;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = SzW;
    bus.ls_addr = 32'h500; bus.ls_wdata = 32'h1122_3344;
    step();
    check("pause byte0 mem_a", bus.mem_a, 32'h500);
    check("pause byte0 mem_dout", {24'b0, bus.mem_dout}, 32'h44);
    step();
    check("pause byte1 mem_a", bus.mem_a, 32'h501);
    en = 1'b0;
    #1;
    check("pause cycle1 mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    step();
    check("pause cycle2 mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    en = 1'b1;
    #1;
    check("restart mem_a", bus.mem_a, 32'h500);
    check("restart mem_wr", {31'b0, bus.mem_wr}, 32'h1);
    found = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (bus.ls_ok) begin found = n; break; end
    end
    check("restart ok cycle", 32'(found), 32'd4);
    bus.ls_req = 1'b0;
    step();
    check("restart ram", ram_word(32'h500), 32'h1122_3344);
    check("restart write count", 32'(wr_count - w0), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
